// File: rtl/ga_reg_ctrl_pkg.sv
// Shared definitions for the Gate Array register controller: function codes,
// palette geometry, FSM encoding and the sampled Z80 bus record.
package ga_pkg;
  localparam logic [1:0] GA_FN_PEN  = 2'b00;
  localparam logic [1:0] GA_FN_INK  = 2'b01;
  localparam logic [1:0] GA_FN_CTRL = 2'b10;
  localparam logic [1:0] GA_FN_RSV  = 2'b11;

  localparam int GA_BORDER_IDX = 16;
  localparam int GA_INK_W      = 5;
  localparam int GA_NUM_ENT    = 17;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_SETTLE  = 3'd1,
    ST_CAPTURE = 3'd2,
    ST_COMMIT  = 3'd3,
    ST_RELEASE = 3'd4
  } ga_state_e;

  typedef struct packed {
    logic       iorq_n;
    logic       wr_n;
    logic       m1_n;
    logic       a15;
    logic       a14;
    logic [7:0] d;
  } ga_bus_t;

  // Gate Array answers a non-M1 I/O write with A15=1, A14=0.
  function automatic logic ga_sel(input ga_bus_t b);
    return ~b.iorq_n & ~b.wr_n & b.m1_n & ~b.a14 & b.a15;
  endfunction
endpackage

// File: rtl/ga_reg_ctrl_if.sv
// Z80 I/O bus as seen by the Gate Array register controller.
interface ga_reg_ctrl_if;
  logic       IORQ_N;
  logic       WR_N;
  logic       M1_N;
  logic       A15;
  logic       A14;
  logic [7:0] D;

  modport master (output IORQ_N, WR_N, M1_N, A15, A14, D);
  modport slave  (input  IORQ_N, WR_N, M1_N, A15, A14, D);
endinterface

// File: rtl/ga_reg_ctrl_palette.sv
// 17x5 palette register file (16 pens + border): one synchronous write port,
// one combinational read port, every entry reset to INK_RST.
module ga_palette
  import ga_pkg::*;
#(
  parameter logic [GA_INK_W-1:0] INK_RST = 5'h14
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                we,
  input  logic [4:0]          waddr,
  input  logic [GA_INK_W-1:0] wdata,
  input  logic [3:0]          rpen,
  input  logic                rborder,
  output logic [GA_INK_W-1:0] rdata
);
  logic [GA_INK_W-1:0] ent [GA_NUM_ENT];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < GA_NUM_ENT; i++) ent[i] <= INK_RST;
    end else if (we) begin
      for (int i = 0; i < GA_NUM_ENT; i++)
        if (waddr == 5'(i)) ent[i] <= wdata;
    end
  end

  assign rdata = rborder ? ent[GA_BORDER_IDX] : ent[{1'b0, rpen}];
endmodule

// File: rtl/ga_reg_ctrl.sv
// Gate Array register controller: filters and decodes 0x7Fxx I/O writes,
// holds pen/ink/mode/ROM configuration and defers mode changes to mode_sync_en.
module ga_reg_ctrl
  import ga_pkg::*;
#(
  parameter int                  SETTLE   = 2,
  parameter logic [GA_INK_W-1:0] INK_RST  = 5'h14,
  parameter logic [1:0]          MODE_RST = 2'd1
) (
  input  logic                clk,
  input  logic                RESET,
  ga_reg_ctrl_if.slave        bus,
  input  logic                mode_sync_en,
  input  logic [3:0]          pix_pen,
  input  logic                pix_border,
  output logic [GA_INK_W-1:0] pix_ink,
  output logic [1:0]          mode,
  output logic                mode_pending,
  output logic                rom_lo_dis,
  output logic                rom_hi_dis,
  output logic                irq_reset,
  output logic                busy
);
  ga_bus_t   bus_r;
  ga_state_e state;
  logic      sel;
  logic [2:0] cnt;
  logic [7:0] data_r;
  logic [3:0] pen_ptr;
  logic       border_flag;
  logic [1:0] mode_nxt;
  logic       commit;
  logic [1:0] fn;
  logic       pal_we;
  logic [4:0] pal_waddr;

  assign sel       = ga_sel(bus_r);
  assign commit    = (state == ST_COMMIT);
  assign fn        = data_r[7:6];
  assign pal_we    = commit && (fn == GA_FN_INK);
  assign pal_waddr = border_flag ? 5'(GA_BORDER_IDX) : {1'b0, pen_ptr};

  always_ff @(posedge clk or posedge RESET) begin
    if (RESET) begin
      bus_r        <= '{iorq_n: 1'b1, wr_n: 1'b1, m1_n: 1'b1, a15: 1'b0, a14: 1'b0, d: 8'h00};
      state        <= ST_IDLE;
      cnt          <= 3'd0;
      data_r       <= 8'h00;
      pen_ptr      <= 4'd0;
      border_flag  <= 1'b0;
      mode         <= MODE_RST;
      mode_nxt     <= MODE_RST;
      mode_pending <= 1'b0;
      rom_lo_dis   <= 1'b0;
      rom_hi_dis   <= 1'b0;
      irq_reset    <= 1'b0;
      busy         <= 1'b0;
    end else begin
      bus_r     <= '{iorq_n: bus.IORQ_N, wr_n: bus.WR_N, m1_n: bus.M1_N,
                     a15: bus.A15, a14: bus.A14, d: bus.D};
      irq_reset <= 1'b0;

      case (state)
        ST_IDLE: if (sel) begin
          state <= ST_SETTLE;
          cnt   <= 3'd1;
          busy  <= 1'b1;
        end
        ST_SETTLE: begin
          if (!sel) begin
            state <= ST_IDLE;
            busy  <= 1'b0;
          end else if (cnt == 3'(SETTLE)) begin
            state <= ST_CAPTURE;
          end else begin
            cnt <= cnt + 3'd1;
          end
        end
        ST_CAPTURE: begin
          data_r    <= bus_r.d;
          state     <= ST_COMMIT;
          // Registered so the pulse spans exactly the COMMIT cycle.
          irq_reset <= (bus_r.d[7:6] == GA_FN_CTRL) && bus_r.d[4];
        end
        ST_COMMIT: begin
          case (fn)
            GA_FN_PEN: begin
              if (data_r[4]) begin
                border_flag <= 1'b1;
              end else begin
                border_flag <= 1'b0;
                pen_ptr     <= data_r[3:0];
              end
            end
            GA_FN_CTRL: begin
              rom_lo_dis <= data_r[2];
              rom_hi_dis <= data_r[3];
            end
            default: ;
          endcase
          state <= ST_RELEASE;
        end
        ST_RELEASE: if (!sel) begin
          state <= ST_IDLE;
          busy  <= 1'b0;
        end
        default: begin
          state <= ST_IDLE;
          busy  <= 1'b0;
        end
      endcase

      // A control commit wins over a coincident sync pulse: the fresh value
      // stays pending and the older pending value is dropped.
      if (commit && (fn == GA_FN_CTRL)) begin
        mode_nxt     <= data_r[1:0];
        mode_pending <= 1'b1;
      end else if (mode_sync_en && mode_pending) begin
        mode         <= mode_nxt;
        mode_pending <= 1'b0;
      end
    end
  end

  ga_palette #(.INK_RST(INK_RST)) u_palette (
    .clk     (clk),
    .rst     (RESET),
    .we      (pal_we),
    .waddr   (pal_waddr),
    .wdata   (data_r[4:0]),
    .rpen    (pix_pen),
    .rborder (pix_border),
    .rdata   (pix_ink)
  );
endmodule

// File: tb/tb_ga_reg_ctrl.sv
// Self-checking bench for ga_reg_ctrl: reset state, table vectors, multi-cycle
// corner sequences and randomized writes against a behavioural model.
module tb_ga_reg_ctrl;
  logic       clk = 1'b0;
  logic       RESET = 1'b1;
  logic       mode_sync_en = 1'b0;
  logic [3:0] pix_pen = 4'd0;
  logic       pix_border = 1'b0;
  logic [4:0] pix_ink;
  logic [1:0] mode;
  logic       mode_pending, rom_lo_dis, rom_hi_dis, irq_reset, busy;

  int total = 0;
  int bad   = 0;
  int irq_cnt = 0;

  ga_reg_ctrl_if bus();

  ga_reg_ctrl dut (
    .clk(clk), .RESET(RESET), .bus(bus), .mode_sync_en(mode_sync_en),
    .pix_pen(pix_pen), .pix_border(pix_border), .pix_ink(pix_ink),
    .mode(mode), .mode_pending(mode_pending), .rom_lo_dis(rom_lo_dis),
    .rom_hi_dis(rom_hi_dis), .irq_reset(irq_reset), .busy(busy)
  );

  always #5 clk = ~clk;
  always @(negedge clk) if (irq_reset) irq_cnt++;

  // Behavioural model of the visible configuration.
  logic [4:0] m_pal [17];
  int         m_pen;
  bit         m_bord, m_pf, m_lo, m_hi;
  logic [1:0] m_mode, m_pend;

  typedef struct {
    logic [7:0] d;
    logic [3:0] rpen;
    logic       rbord;
    logic [4:0] exp_ink;
    logic       exp_lo;
    logic       exp_hi;
  } vec_t;
  vec_t vecs[9];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic bus_idle();
    bus.IORQ_N = 1'b1; bus.WR_N = 1'b1; bus.M1_N = 1'b1;
    bus.A15 = 1'b1; bus.A14 = 1'b0;
  endtask

  // q: 0 qualified, 1 A15=0, 2 M1_N=0, 3 A14=1
  task automatic strobe_on(input logic [7:0] d, input int q);
    bus.D = d;
    bus.A15 = (q != 1); bus.M1_N = (q != 2); bus.A14 = (q == 3);
    bus.IORQ_N = 1'b0; bus.WR_N = 1'b0;
  endtask

  task automatic io_write(input logic [7:0] d, input int hold, input int q);
    strobe_on(d, q);
    cyc(hold);
    bus_idle();
    cyc(4);
  endtask

  task automatic sync_pulse();
    mode_sync_en = 1'b1;
    cyc(1);
    mode_sync_en = 1'b0;
    cyc(1);
  endtask

  task automatic model_reset();
    for (int i = 0; i < 17; i++) m_pal[i] = 5'h14;
    m_pen = 0; m_bord = 0; m_pf = 0; m_lo = 0; m_hi = 0;
    m_mode = 2'd1; m_pend = 2'd1;
  endtask

  task automatic model_write(input logic [7:0] d);
    case (d[7:6])
      2'b00: if (d[4]) m_bord = 1; else begin m_bord = 0; m_pen = int'(d[3:0]); end
      2'b01: m_pal[m_bord ? 16 : m_pen] = d[4:0];
      2'b10: begin m_pend = d[1:0]; m_pf = 1; m_lo = d[2]; m_hi = d[3]; end
      default: ;
    endcase
  endtask

  task automatic model_sync();
    if (m_pf) begin m_mode = m_pend; m_pf = 0; end
  endtask

  task automatic do_reset();
    RESET = 1'b1;
    bus_idle();
    mode_sync_en = 1'b0;
    cyc(2);
    RESET = 1'b0;
    cyc(2);
    model_reset();
  endtask

  function automatic logic [4:0] read_ink(input int p, input bit b);
    return 5'h0;
  endfunction

  task automatic rd(input logic [3:0] p, input logic b);
    pix_pen = p; pix_border = b;
    #1;
  endtask

  initial begin
    bit found;
    int hold, q, n_entry;
    logic [7:0] d;
    bus.D = 8'h00;
    bus_idle();
    cyc(2);
    RESET = 1'b0;
    cyc(2);
    model_reset();

    // Reset state
    for (int i = 0; i < 16; i++) begin
      rd(4'(i), 1'b0);
      chk($sformatf("rst_pen%0d", i), 32'(pix_ink), 32'h14);
    end
    rd(4'd0, 1'b1);
    chk("rst_border", 32'(pix_ink), 32'h14);
    chk("rst_mode", 32'(mode), 32'd1);
    chk("rst_pending", 32'(mode_pending), 32'd0);
    chk("rst_rom_lo", 32'(rom_lo_dis), 32'd0);
    chk("rst_rom_hi", 32'(rom_hi_dis), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_irq", 32'(irq_reset), 32'd0);

    // Table vectors: one write, then one read and the ROM bits.
    vecs[0] = '{8'h03, 4'd3, 1'b0, 5'h14, 1'b0, 1'b0};
    vecs[1] = '{8'h4A, 4'd3, 1'b0, 5'h0A, 1'b0, 1'b0};
    vecs[2] = '{8'h10, 4'd0, 1'b1, 5'h14, 1'b0, 1'b0};
    vecs[3] = '{8'h44, 4'd0, 1'b1, 5'h04, 1'b0, 1'b0};
    vecs[4] = '{8'h00, 4'd3, 1'b0, 5'h0A, 1'b0, 1'b0};
    vecs[5] = '{8'hC5, 4'd3, 1'b0, 5'h0A, 1'b0, 1'b0};
    vecs[6] = '{8'h8C, 4'd2, 1'b0, 5'h14, 1'b1, 1'b1};
    vecs[7] = '{8'h80, 4'd0, 1'b1, 5'h04, 1'b0, 1'b0};
    vecs[8] = '{8'h51, 4'd0, 1'b0, 5'h11, 1'b0, 1'b0};
    for (int i = 0; i < 9; i++) begin
      io_write(vecs[i].d, 6, 0);
      rd(vecs[i].rpen, vecs[i].rbord);
      chk($sformatf("vec%0d_ink", i), 32'(pix_ink), 32'(vecs[i].exp_ink));
      chk($sformatf("vec%0d_lo", i), 32'(rom_lo_dis), 32'(vecs[i].exp_lo));
      chk($sformatf("vec%0d_hi", i), 32'(rom_hi_dis), 32'(vecs[i].exp_hi));
    end

    // Control write with IRQ reset, then mode apply at sync.
    do_reset();
    irq_cnt = 0;
    io_write(8'h9E, 6, 0);
    chk("ctrl_irq_once", 32'(irq_cnt), 32'd1);
    chk("ctrl_rom_lo", 32'(rom_lo_dis), 32'd1);
    chk("ctrl_rom_hi", 32'(rom_hi_dis), 32'd1);
    chk("ctrl_pending", 32'(mode_pending), 32'd1);
    chk("ctrl_mode_held", 32'(mode), 32'd1);
    sync_pulse();
    chk("ctrl_mode_applied", 32'(mode), 32'd2);
    chk("ctrl_pending_clr", 32'(mode_pending), 32'd0);

    // Last write wins.
    io_write(8'h80, 6, 0);
    io_write(8'h83, 6, 0);
    sync_pulse();
    chk("lastwin_mode", 32'(mode), 32'd3);

    // Commit coincident with sync: new value stays pending, old one dropped.
    io_write(8'h81, 6, 0);
    strobe_on(8'h92, 0);
    found = 0;
    for (int i = 0; i < 20 && !found; i++) begin
      @(negedge clk);
      if (irq_reset) found = 1;
    end
    chk("coinc_irq_seen", 32'(found), 32'd1);
    mode_sync_en = 1'b1;
    cyc(1);
    mode_sync_en = 1'b0;
    bus_idle();
    cyc(4);
    chk("coinc_mode_kept", 32'(mode), 32'd3);
    chk("coinc_pending", 32'(mode_pending), 32'd1);
    sync_pulse();
    chk("coinc_mode_next", 32'(mode), 32'd2);
    sync_pulse();
    chk("sync_nopend_mode", 32'(mode), 32'd2);

    // Short strobes are discarded as glitches.
    io_write(8'h05, 6, 0);
    io_write(8'h4F, 1, 0);
    rd(4'd5, 1'b0);
    chk("glitch1_ink", 32'(pix_ink), 32'h14);
    io_write(8'h4F, 2, 0);
    rd(4'd5, 1'b0);
    chk("glitch2_ink", 32'(pix_ink), 32'h14);
    chk("glitch_busy", 32'(busy), 32'd0);

    // Long strobe: one commit only, data changes after it are ignored.
    strobe_on(8'h41, 0);
    cyc(20);
    bus.D = 8'h42;
    cyc(29);
    chk("long_busy", 32'(busy), 32'd1);
    bus_idle();
    cyc(4);
    rd(4'd5, 1'b0);
    chk("long_ink", 32'(pix_ink), 32'h01);
    chk("long_busy_end", 32'(busy), 32'd0);

    // Unqualified cycles are ignored.
    for (int k = 1; k <= 3; k++) begin
      io_write(8'h4C, 6, k);
      rd(4'd5, 1'b0);
      chk($sformatf("unqual%0d_ink", k), 32'(pix_ink), 32'h01);
    end

    // Reset during SETTLE aborts the write.
    do_reset();
    strobe_on(8'h5F, 0);
    cyc(2);
    chk("abort_busy_before", 32'(busy), 32'd1);
    RESET = 1'b1;
    #1;
    chk("abort_busy_now", 32'(busy), 32'd0);
    bus_idle();
    cyc(2);
    RESET = 1'b0;
    cyc(8);
    n_entry = 0;
    for (int i = 0; i < 16; i++) begin
      rd(4'(i), 1'b0);
      if (pix_ink == 5'h14) n_entry++;
    end
    chk("abort_pal_clean", 32'(n_entry), 32'd16);
    chk("abort_busy_idle", 32'(busy), 32'd0);

    // Strobe already high when RESET releases: write is accepted.
    RESET = 1'b1;
    strobe_on(8'h4B, 0);
    cyc(2);
    RESET = 1'b0;
    cyc(8);
    bus_idle();
    cyc(4);
    rd(4'd0, 1'b0);
    chk("post_rst_write", 32'(pix_ink), 32'h0B);

    // Randomized writes against the model.
    do_reset();
    for (int it = 0; it < 60; it++) begin
      d = 8'($urandom);
      q = ($urandom_range(0, 7) == 0) ? int'($urandom_range(1, 3)) : 0;
      hold = ($urandom_range(0, 5) == 0) ? int'($urandom_range(1, 2)) : int'($urandom_range(5, 9));
      io_write(d, hold, q);
      if (q == 0 && hold >= 5) model_write(d);
      if ($urandom_range(0, 2) == 0) begin
        sync_pulse();
        model_sync();
      end
      pix_pen = 4'($urandom_range(0, 15));
      pix_border = 1'b0;
      #1;
      chk("rnd_pen", 32'(pix_ink), 32'(m_pal[int'(pix_pen)]));
      rd(4'd0, 1'b1);
      chk("rnd_border", 32'(pix_ink), 32'(m_pal[16]));
      chk("rnd_mode", 32'(mode), 32'(m_mode));
      chk("rnd_pending", 32'(mode_pending), 32'(m_pf));
      chk("rnd_rom", {30'd0, rom_hi_dis, rom_lo_dis}, {30'd0, m_hi, m_lo});
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/ga_reg_ctrl.md
Name: ga_reg_ctrl

Overview:
- Gate Array register controller: decodes CPU I/O writes to the 40010 port (pen select, ink, mode/ROM/IRQ control) and holds the resulting configuration.
- Owns the 17-entry palette (16 pens + border). Sequences mode changes so a new mode takes effect only on the `mode_sync_en` pulse from the sync/int generator.
- Generates the one-cycle `irq_reset` pulse consumed by the sync/int generator.
- Sits between the Z80 bus interface and the sync/int generator plus the pixel pipeline.

Parameters:
- `SETTLE`, 2, number of consecutive clk cycles the qualified write strobe must be stable before capture (glitch filter, 1..7).
- `INK_RST`, 5'h14, reset hardware colour loaded into every palette entry.
- `MODE_RST`, 2'd1, reset value of both the active and the pending mode.

Ports:
- `clk`  in  1  system clock
- `RESET`  in  1  asynchronous active-high reset
- `IORQ_N`  in  1  Z80 I/O request
- `WR_N`  in  1  Z80 write strobe
- `M1_N`  in  1  Z80 M1 (write ignored while low)
- `A15`  in  1  address bit 15
- `A14`  in  1  address bit 14
- `D`  in  8  CPU data bus
- `mode_sync_en`  in  1  one-clk pulse from the sync/int generator; mode apply point
- `pix_pen`  in  4  pen index for the pixel read port
- `pix_border`  in  1  1 = read the border entry instead of `pix_pen`
- `pix_ink`  out  5  combinational palette read result
- `mode`  out  2  active screen mode
- `mode_pending`  out  1  a written mode is awaiting `mode_sync_en`
- `rom_lo_dis`  out  1  lower ROM disable
- `rom_hi_dis`  out  1  upper ROM disable
- `irq_reset`  out  1  one-clk pulse: clear interrupt counter / INT
- `busy`  out  1  FSM not in IDLE

Behaviour:
- Qualified strobe `sel = ~IORQ_N & ~WR_N & M1_N & ~A14 & A15`, evaluated from registered copies of the inputs.
- Reset (async, RESET=1):
  - FSM=IDLE.
  - Pen pointer=0, border flag=0.
  - All 17 palette entries=INK_RST.
  - `mode`=MODE_RST, pending mode=MODE_RST, `mode_pending`=0.
  - `rom_lo_dis`=0, `rom_hi_dis`=0, `irq_reset`=0, `busy`=0.
- FSM states:
  - IDLE: `sel`=1 -> SETTLE, count=1.
  - SETTLE: `sel`=0 -> IDLE (glitch discarded). `sel`=1 and count==SETTLE -> CAPTURE. Otherwise count+1.
  - CAPTURE: latch D into a data register -> COMMIT.
  - COMMIT: apply the function selected by D[7:6] in one clk -> RELEASE.
  - RELEASE: wait for `sel`=0 -> IDLE. Exactly one commit per I/O cycle, however long the strobe is held.
- Minimum latency from first registered `sel`=1 to the commit edge: SETTLE+2 clk.
- Functions on D[7:6]:
  - 00 pen select: D[4]=1 -> border flag=1; else border flag=0 and pen pointer=D[3:0].
  - 01 ink: write D[4:0] to the border entry if border flag=1, else to entry[pen pointer]. The write is visible on `pix_ink` the cycle after COMMIT.
  - 10 control: pending mode=D[1:0] and `mode_pending`=1; `rom_lo_dis`=D[2], `rom_hi_dis`=D[3] (update at COMMIT). D[4]=1 -> `irq_reset`=1 for exactly the COMMIT cycle.
  - 11 reserved: no state change, FSM still walks COMMIT -> RELEASE.
- Mode sequencing:
  - On `mode_sync_en`=1 with `mode_pending`=1: `mode`<=pending mode, `mode_pending`<=0.
  - Several mode writes before a sync pulse: last write wins.
  - Control write COMMIT in the same cycle as `mode_sync_en`: the newly written value stays pending (`mode_pending`=1) and the old pending value is discarded, not applied. The new value is applied at the next pulse.
  - `mode_sync_en` with `mode_pending`=0: no effect.
- Palette read: `pix_ink` = entry[16] if `pix_border`, else entry[`pix_pen`]. Read is combinational; pixel timing is the consumer's responsibility.
- RESET asserted mid-operation aborts any transaction; no partial commit.
- After RESET release while `sel` is already high: the FSM enters SETTLE normally (write accepted).

Decomposition:
- Shared package `ga_pkg`:
  - function codes `GA_FN_PEN`=2'b00, `GA_FN_INK`=2'b01, `GA_FN_CTRL`=2'b10, `GA_FN_RSV`=2'b11
  - `GA_BORDER_IDX`=16
  - `GA_INK_W`=5
  - FSM state encoding
- Sub-module `ga_palette`: 17x5 register file with async reset to INK_RST, one synchronous write port and one combinational read port.

Test Plan:
- Reset then read: `pix_pen`=0..15 and border all give 5'h14; `mode`=1; `rom_lo_dis`=0; `rom_hi_dis`=0.
- Write 0x03 then 0x4A (each I/O cycle >= SETTLE+3 clk) -> entry3=5'h0A; other entries unchanged. Write 0x10 then 0x44 -> border=5'h04, entry3 still 5'h0A.
- Write 0x9E -> `rom_lo_dis`=1, `rom_hi_dis`=1, `irq_reset` high exactly one clk, `mode_pending`=1 with pending=2. `mode` stays 1 until `mode_sync_en`, then `mode`=2 and `mode_pending`=0.
- Write 0x80 then 0x83 before any sync pulse -> one `mode_sync_en` gives `mode`=3. Commit coincident with `mode_sync_en` -> `mode` unchanged; applied at the following pulse.
- Strobe pulse of SETTLE-1 clk -> no state change. Strobe held 50 clk with D=0x41 -> exactly one ink write. A15=0 or M1_N=0 -> ignored.
- Assert RESET during SETTLE of a 0x5F write -> no palette change; FSM IDLE; `busy`=0 immediately.
